// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer and related front-end logic.
// Ports: none (package). Provides the 2-bit debouncer state type, default
// parameter values and a helper that sizes the stability counter.
package debounce_pkg;

   // Bit 1 of every encoding is the debounced level, so w can be read
   // straight from the state register in both IDLE and WAIT states.
   typedef enum logic [1:0] {
      IDLE_LO = 2'b00,
      WAIT_HI = 2'b01,
      IDLE_HI = 2'b10,
      WAIT_LO = 2'b11
   } state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 4;

   // Counter width: max(1, clog2(n)).
   function automatic int cnt_width(input int n);
      int b;
      b = $clog2(n);
      return (b < 1) ? 1 : b;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop-chain synchroniser for one asynchronous input bit.
// Ports: clk, rst (sync, active-high), d (async input), q (synchronised output).
// Latency SYNC_STAGES cycles; no logic between stages.
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (rst) begin
         ff <= '0;
      end else begin
         ff <= {ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a bouncy external level into a clean synchronous bit w with rise/fall strobes.
// Ports: clk, rst (sync, active-high), raw_in (async level), w (debounced level),
// w_rise / w_fall (one-cycle strobes registered alongside the new w value).
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic w,
   output logic w_rise,
   output logic w_fall
);

   localparam int             CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   logic          sync_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_d, fall_d;
   logic          differ;

   sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw_in),
      .q   (sync_q)
   );

   // Synchronised input disagrees with the current debounced level.
   assign differ = (sync_q != state_q[1]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         IDLE_LO, IDLE_HI: begin
            if (!differ) begin
               cnt_d = '0;
            end else if (STABLE_CYCLES == 1) begin
               // A single differing sample is already a full count.
               state_d = state_q[1] ? IDLE_LO : IDLE_HI;
               rise_d  = !state_q[1];
               fall_d  = state_q[1];
               cnt_d   = '0;
            end else begin
               state_d = state_q[1] ? WAIT_LO : WAIT_HI;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_HI, WAIT_LO: begin
            if (!differ) begin
               // Glitch: candidate level did not persist, drop it.
               state_d = state_q[1] ? IDLE_HI : IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = state_q[1] ? IDLE_LO : IDLE_HI;
               rise_d  = !state_q[1];
               fall_d  = state_q[1];
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         w_rise  <= 1'b0;
         w_fall  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_rise  <= rise_d;
         w_fall  <= fall_d;
      end
   end

   assign w = state_q[1];

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with default parameters.
// Directed latency/boundary scenarios followed by randomized hold-length stimulus,
// all compared every cycle against a behavioural reference model.
module tb_input_debouncer;

   localparam int SYNC = 2;
   localparam int STAB = 4;
   localparam int LAT  = SYNC + STAB;

   logic clk = 1'b0;
   logic rst;
   logic raw_in;
   logic w, w_rise, w_fall;

   int total = 0;
   int bad   = 0;
   int n_rise = 0;
   int n_fall = 0;

   always #5 clk = ~clk;

   input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB)) dut (
      .clk    (clk),
      .rst    (rst),
      .raw_in (raw_in),
      .w      (w),
      .w_rise (w_rise),
      .w_fall (w_fall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: raw_in reaches the decision point SYNC edges late; the
   // debounced level flips once STAB consecutive decision samples disagree
   // with it, counted afresh after every flip, glitch or reset.
   logic [SYNC-1:0] m_delay;
   logic            m_vis;
   logic            m_w, m_rise, m_fall;
   int              m_run;

   always @(posedge clk) begin
      if (rst) begin
         m_delay = '0;
         m_w     = 1'b0;
         m_rise  = 1'b0;
         m_fall  = 1'b0;
         m_run   = 0;
      end else begin
         m_vis   = m_delay[SYNC-1];
         m_delay = {m_delay[SYNC-2:0], raw_in};
         m_rise  = 1'b0;
         m_fall  = 1'b0;
         if (m_vis != m_w) begin
            m_run++;
            if (m_run >= STAB) begin
               m_w    = ~m_w;
               m_rise = m_w;
               m_fall = ~m_w;
               m_run  = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      #1;
      chk("w", w, m_w);
      chk("w_rise", w_rise, m_rise);
      chk("w_fall", w_fall, m_fall);
      if (w_rise === 1'b1) n_rise++;
      if (w_fall === 1'b1) n_fall++;
   end

   // Drive raw_in before calling; the next rising edge is counted as edge 1.
   task automatic wait_w(input logic val, input int exp_edges, input string tag);
      int  n;
      bit  seen;
      n    = 0;
      seen = 0;
      while (!seen && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (w === val) seen = 1;
      end
      chk(tag, n, exp_edges);
   endtask

   task automatic hold(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      int r0, f0, width, len;

      // Reset with raw_in already high; w must rise with full latency.
      rst    = 1'b1;
      raw_in = 1'b1;
      hold(3);
      chk("reset_w", w, 0);
      chk("reset_rise", w_rise, 0);
      chk("reset_state", dut.state_q, 2'b00);
      chk("reset_cnt", dut.cnt_q, 0);
      rst = 1'b0;
      wait_w(1'b1, LAT, "post_reset_latency");
      chk("post_reset_rises", n_rise, 1);
      chk("post_reset_no_fall", n_fall, 0);

      // Return low, then a clean press.
      raw_in = 1'b0;
      wait_w(1'b0, LAT, "release_latency");
      hold(5);
      r0 = n_rise;
      f0 = n_fall;
      raw_in = 1'b1;
      wait_w(1'b1, LAT, "press_latency");
      hold(14);
      chk("press_one_rise", n_rise, r0 + 1);
      raw_in = 1'b0;
      wait_w(1'b0, LAT, "press_release_latency");
      hold(5);
      chk("press_one_fall", n_fall, f0 + 1);

      // Bounce 1,0,1,0 at 2-cycle spacing, then settle high.
      r0 = n_rise;
      raw_in = 1'b1; hold(2);
      raw_in = 1'b0; hold(2);
      raw_in = 1'b1; hold(2);
      raw_in = 1'b0; hold(2);
      chk("bounce_w_low", w, 0);
      raw_in = 1'b1;
      wait_w(1'b1, LAT, "bounce_latency");
      chk("bounce_one_rise", n_rise, r0 + 1);
      raw_in = 1'b0;
      wait_w(1'b0, LAT, "bounce_release");
      hold(4);

      // 3-cycle glitch is rejected.
      r0 = n_rise;
      raw_in = 1'b1; hold(3);
      raw_in = 1'b0; hold(12);
      chk("glitch3_no_rise", n_rise, r0);
      chk("glitch3_w", w, 0);

      // 4-cycle pulse is accepted and yields a 4-cycle w pulse.
      r0 = n_rise;
      f0 = n_fall;
      width = 0;
      raw_in = 1'b1; hold(4);
      raw_in = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (w === 1'b1) width++;
      end
      chk("pulse4_width", width, STAB);
      chk("pulse4_rise", n_rise, r0 + 1);
      chk("pulse4_fall", n_fall, f0 + 1);

      // Reset in the middle of a count.
      raw_in = 1'b1;
      hold(4);
      chk("midcnt_state", dut.state_q, 2'b01);
      chk("midcnt_cnt", dut.cnt_q, 2);
      rst = 1'b1;
      hold(1);
      chk("midrst_state", dut.state_q, 2'b00);
      chk("midrst_cnt", dut.cnt_q, 0);
      chk("midrst_w", w, 0);
      rst = 1'b0;
      wait_w(1'b1, LAT, "midrst_latency");

      // Randomized hold lengths around the acceptance threshold, occasional reset.
      for (int seg = 0; seg < 400; seg++) begin
         raw_in = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 2 * STAB + 1);
         if ($urandom_range(0, 63) == 0) begin
            rst = 1'b1;
            hold($urandom_range(1, 3));
            rst = 1'b0;
         end
         hold(len);
      end
      hold(LAT + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Front-end conditioning stage that turns an asynchronous, bouncy external input (push-button or slide switch) into the clean, clock-synchronous serial bit `w` consumed by the two-successive-ones Moore detector. It synchronises the raw pin, then accepts a level change only after the synchronised value has been stable for a programmable number of cycles. It also emits single-cycle rise/fall strobes for downstream counters.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count, ≥2.
- `STABLE_CYCLES`, default 4: consecutive cycles a new level must persist before `w` follows, ≥1.
- `clk`  input  1  single clock; all flops rising-edge.
- `rst`  input  1  reset, synchronous and active-high.
- `raw_in`  input  1  asynchronous external level.
- `w`  output  1  debounced level, registered.
- `w_rise`  output  1  one-cycle strobe, high in the cycle after `w` goes 0→1.
- `w_fall`  output  1  one-cycle strobe, high in the cycle after `w` goes 1→0.

## Operation
- Synchroniser: `raw_in` → `SYNC_STAGES` flops → `sync_q`. No logic between stages.
- Counter `cnt`: width `max(1, $clog2(STABLE_CYCLES))`, unsigned. It never exceeds `STABLE_CYCLES-1` and never wraps.
- FSM states:
  - `IDLE_LO`: `w`=0, stable.
  - `WAIT_HI`: `w`=0, counting a candidate 1.
  - `IDLE_HI`: `w`=1, stable.
  - `WAIT_LO`: `w`=1, counting a candidate 0.
- Transitions, evaluated each edge:
  - IDLE_x, `sync_q`==`w`: stay; `cnt`=0.
  - IDLE_x, `sync_q`!=`w`:
    - If `STABLE_CYCLES`==1: flip `w`, go to the opposite IDLE, pulse the strobe.
    - Otherwise: go to WAIT_x; `cnt`=1.
  - WAIT_x, `sync_q`==`w` (glitch): return to IDLE_x; `cnt`=0. Candidate discarded.
  - WAIT_x, `sync_q`!=`w`, `cnt`<`STABLE_CYCLES-1`: `cnt`+1.
  - WAIT_x, `sync_q`!=`w`, `cnt`==`STABLE_CYCLES-1`: flip `w`, go to the opposite IDLE, `cnt`=0, assert `w_rise`/`w_fall` for exactly one cycle.
- `w_rise` and `w_fall` are never high together. Each is high for at most one cycle per `w` transition.
- Reset, any cycle including mid-WAIT:
  - all sync flops = 0, `w`=0, `cnt`=0, state `IDLE_LO`, `w_rise`=`w_fall`=0.
  - Any in-progress count is lost. Reset has priority over all transitions.
- If `raw_in` is high when reset releases: normal 0→1 acceptance, with full latency and a `w_rise` strobe.

## Timing
- Latency: `w` changes on edge `SYNC_STAGES+STABLE_CYCLES`, counting the first edge that samples the new `raw_in` as edge 1. Defaults give 6 edges; `STABLE_CYCLES`=1 gives 3.
- The strobe is visible in the same cycle as the new `w` value, i.e. registered alongside `w`.
- Rejection: a `sync_q` excursion shorter than `STABLE_CYCLES` cycles never reaches `w`. An excursion of exactly `STABLE_CYCLES` cycles is accepted.
- Back-to-back changes: after a flip, a reversal needs a fresh full `STABLE_CYCLES` count. Minimum `w` pulse width is `STABLE_CYCLES` cycles.
- Outputs are glitch-free: `w` is a flop, with no combinational path from `raw_in`.

## Structure
- Shared package `debounce_pkg`:
  - 2-bit state typedef with encodings `IDLE_LO`=2'b00, `WAIT_HI`=2'b01, `IDLE_HI`=2'b10, `WAIT_LO`=2'b11.
  - `w` equals `state[1]` in IDLE states.
  - Default parameter constants.
- Sub-module `sync_chain`: parameter `SYNC_STAGES`; ports `clk`, `rst`, `d`, `q`. It is reused for other external inputs.
- FSM, counter and strobe logic stay in `input_debouncer`: one sequential block plus one next-state combinational block.

## Test plan
- **Reset:** hold `rst` 3 cycles with `raw_in`=1, release → `w`=0 for 5 cycles, `w`=1 with `w_rise`=1 on edge 6; `w_fall` never asserted.
- **Clean press:** defaults, `raw_in` 0→1 held 20 cycles → `w` rises on edge 6, `w_rise` high exactly 1 cycle. Release → `w` falls 6 edges later, with a single `w_fall`.
- **Bounce:** `raw_in` toggles 1,0,1,0 at 2-cycle spacing, then holds 1 → `w` stays 0 during the bounce and rises 6 edges after the final 0→1. Exactly one `w_rise`.
- **Boundary:**
  - a 3-cycle high glitch → `w` unchanged;
  - a 4-cycle high pulse → `w`=1 for exactly 4 cycles, then falls after a fresh 4-cycle low.
- **Reset mid-count:** assert `rst` while in `WAIT_HI` with `cnt`=2 → next cycle state `IDLE_LO`, `cnt`=0, `w`=0. After release, the full 6-edge latency applies again.
- **Integration:** drive the debouncer into the two-ones detector; `raw_in`=1 for 30 cycles → detector `z` asserts 2 cycles after `w` rises.
